// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss-handling controller for one cache (I or D). When a lookup misses, it
// fetches the whole block from multi-cycle main memory. It issues one word
// read per cycle, back to back, without waiting for returns. Each returned
// word is written straight into the data array. The tag/valid entry is written
// together with the last word. fsm_busy stalls the pipeline from the cycle the
// miss is seen until the fill completes.
//
// Ports:
//   clk                in   clock, rising edge
//   rst                in   asynchronous active-high reset
//   miss_detected      in   cache lookup missed this cycle
//   miss_address       in   byte address of the missing access
//   memory_data_valid  in   memory_data holds the word for the oldest request
//   memory_data        in   returned read data
//   fsm_busy           out  fill in progress (pipeline stall request)
//   memory_read_en     out  issue a read request this cycle
//   memory_address     out  byte address of the request
//   write_data_array   out  write fill_data into the data array this cycle
//   fill_word          out  word index within the block for the data write
//   fill_data          out  data to write (the returned memory word)
//   write_tag_array    out  write tag/valid for the block this cycle
//   fill_base          out  latched block base address (tag/index source)
// -----------------------------------------------------------------------------
module cache_fill_fsm #(
    parameter  int ADDR_W = 16,
    parameter  int WORD_W = 16,
    parameter  int WORDS  = 8,
    localparam int OFF_W  = $clog2(2 * WORDS),
    localparam int IDX_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    input  logic [WORD_W-1:0] memory_data,
    output logic              fsm_busy,
    output logic              memory_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [IDX_W-1:0]  fill_word,
    output logic [WORD_W-1:0] fill_data,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] fill_base
);

    typedef enum logic {
        IDLE,
        FILL
    } stateT;

    localparam logic [IDX_W:0]   REQ_FULL = (IDX_W + 1)'(WORDS);
    localparam logic [IDX_W-1:0] RCV_LAST = IDX_W'(WORDS - 1);

    stateT             state;
    logic [ADDR_W-1:0] base;
    logic [IDX_W:0]    reqCnt;   // requests issued this fill, saturates at WORDS
    logic [IDX_W-1:0]  rcvCnt;   // words received this fill

    logic reqActive;
    logic accept;

    // NOTE: every signal written in an always_comb gets a value on every path,
    // otherwise a latch is inferred.
    always_comb begin
        reqActive = (state == FILL) && (reqCnt < REQ_FULL);
        // A valid pulse only counts when a request is actually outstanding;
        // stray pulses (idle, or before the first request) are dropped.
        accept    = (state == FILL) && memory_data_valid
                    && ({1'b0, rcvCnt} < reqCnt);
    end

    // Stall is raised in the very cycle the miss is seen, before the state
    // register has moved, so the pipeline never advances past a missing access.
    assign fsm_busy         = !rst && ((state == FILL) || ((state == IDLE) && miss_detected));

    assign memory_read_en   = reqActive;
    assign memory_address   = reqActive ? (base + (ADDR_W'(reqCnt) << 1)) : '0;

    // Returned data goes straight to the array in the cycle it is valid.
    assign write_data_array = accept;
    assign fill_word        = accept ? rcvCnt : '0;
    assign fill_data        = accept ? memory_data : '0;
    assign write_tag_array  = accept && (rcvCnt == RCV_LAST);
    assign fill_base        = base;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            base   <= '0;
            reqCnt <= '0;
            rcvCnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base   <= {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        reqCnt <= '0;
                        rcvCnt <= '0;
                        state  <= FILL;
                    end
                end
                FILL: begin
                    if (reqActive) begin
                        reqCnt <= reqCnt + (IDX_W + 1)'(1);
                    end
                    if (accept) begin
                        if (rcvCnt == RCV_LAST) begin
                            // Last word: all requests have been issued, so
                            // both counters can be cleared for the next fill.
                            state  <= IDLE;
                            rcvCnt <= '0;
                            reqCnt <= '0;
                        end else begin
                            rcvCnt <= rcvCnt + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
//
// Directed bench for cache_fill_fsm. A small memory model answers every read
// request after a configurable latency; the returned data is a fixed function
// of the request address. Each request pushes the expected array write
// (word index, data, tag strobe) onto a scoreboard queue, which is popped and
// compared when the DUT performs the data write.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = '0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = '0;
    logic        fsm_busy;
    logic        memory_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;
    logic [15:0] fill_base;

    cache_fill_fsm #(.ADDR_W(16), .WORD_W(16), .WORDS(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .memory_data      (memory_data),
        .fsm_busy         (fsm_busy),
        .memory_read_en   (memory_read_en),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .fill_word        (fill_word),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array),
        .fill_base        (fill_base)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] data;
        logic        tag;
    } wrExpT;

    int vectors = 0;
    int miscompares = 0;

    // stimulus controls
    bit          rstIn = 1'b0;
    bit          missIn = 1'b0;
    logic [15:0] missAddrIn = '0;
    bit          strayValid = 1'b0;
    bit          irregular = 1'b0;
    bit          strict = 1'b0;

    // reference model of the fill
    bit          expFill = 1'b0;
    logic [15:0] expBase = '0;
    int          expReq = 0;
    int          expRcv = 0;
    int          cyc = 0;
    int          lastReady = 0;
    int          pendReady[$];
    logic [15:0] pendAddr[$];
    wrExpT       expQ[$];
    int          gapTab[8] = '{0, 3, 1, 2, 0, 3, 2, 1};

    function automatic logic [15:0] dataFor(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict, sample at negedge, advance model.
    task automatic cycle();
        logic        v;
        logic [15:0] d;
        logic        acc;
        logic        expEn;
        logic        expBusy;
        logic        expWr;
        logic [15:0] expAddr;
        bit          wasFill;
        wrExpT       e;
        int          r;

        v = 1'b0; d = '0; acc = 1'b0;
        rst = rstIn;
        miss_detected = missIn;
        miss_address = missAddrIn;
        if (pendAddr.size() > 0 && pendReady[0] <= cyc) begin
            v = 1'b1;
            d = dataFor(pendAddr[0]);
            acc = !rstIn;
            void'(pendAddr.pop_front());
            void'(pendReady.pop_front());
        end else if (strayValid) begin
            v = 1'b1;
            d = 16'hDEAD;
        end
        memory_data_valid = v;
        memory_data = d;

        if (rstIn) begin
            expFill = 1'b0;
            expBase = '0;
            pendAddr.delete();
            pendReady.delete();
            expQ.delete();
        end
        wasFill = expFill;
        expEn   = expFill && (expReq < 8);
        expAddr = expBase + 16'(2 * expReq);
        expBusy = !rstIn && (expFill || missIn);
        expWr   = acc && expFill;

        @(negedge clk);
        check("fsm_busy", 32'(fsm_busy), 32'(expBusy));
        check("memory_read_en", 32'(memory_read_en), 32'(expEn));
        if (expEn) check("memory_address", 32'(memory_address), 32'(expAddr));
        else if (strict) check("memory_address_idle", 32'(memory_address), 32'd0);
        check("write_data_array", 32'(write_data_array), 32'(expWr));
        check("fill_base", 32'(fill_base), 32'(expBase));
        if (expWr) begin
            e = expQ.pop_front();
            check("fill_word", 32'(fill_word), 32'(e.idx));
            check("fill_data", 32'(fill_data), 32'(e.data));
            check("write_tag_array", 32'(write_tag_array), 32'(e.tag));
        end else begin
            check("write_tag_array_idle", 32'(write_tag_array), 32'd0);
            if (strict) begin
                check("fill_word_idle", 32'(fill_word), 32'd0);
                check("fill_data_idle", 32'(fill_data), 32'd0);
            end
        end

        if (expEn) begin
            if (irregular) begin
                r = lastReady + 1 + gapTab[expReq];
                if (r < cyc + 1) r = cyc + 1;
            end else begin
                r = cyc + 4;
            end
            lastReady = r;
            pendAddr.push_back(expAddr);
            pendReady.push_back(r);
            expQ.push_back('{idx: 3'(expReq), data: dataFor(expAddr), tag: (expReq == 7)});
            expReq++;
        end
        if (expWr) begin
            expRcv++;
            if (expRcv == 8) expFill = 1'b0;
        end else if (!wasFill && missIn && !rstIn) begin
            expFill = 1'b1;
            expBase = {missAddrIn[15:4], 4'h0};
            expReq = 0;
            expRcv = 0;
            lastReady = 0;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic startMiss(input logic [15:0] a);
        missIn = 1'b1;
        missAddrIn = a;
        cycle();
        missIn = 1'b0;
        missAddrIn = 16'h0BAD;  // must not be sampled outside IDLE
    endtask

    task automatic runUntilIdle(input int limit);
        int n = 0;
        while (expFill && n < limit) begin
            cycle();
            n++;
        end
        check("fill_timeout", 32'(expFill), 32'd0);
    endtask

    task automatic runUntilRcv(input int words, input int limit);
        int n = 0;
        while (expRcv < words && n < limit) begin
            cycle();
            n++;
        end
        check("rcv_timeout", 32'(expRcv >= words), 32'd1);
    endtask

    initial begin
        // Reset, then idle with stray valid pulses: every output stays 0.
        strict = 1'b1;
        rstIn = 1'b1;
        cycle();
        cycle();
        rstIn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strayValid = i[0];
            cycle();
        end
        strayValid = 1'b0;
        strict = 1'b0;

        // Fixed latency 4 fill of block 0x1230.
        startMiss(16'h1236);
        runUntilIdle(40);
        cycle();

        // Top of the address space: 0xFFF0..0xFFFE.
        startMiss(16'hFFF8);
        runUntilIdle(40);
        cycle();

        // Irregular return gaps plus a stray valid before the first request.
        irregular = 1'b1;
        startMiss(16'h0A5E);
        strayValid = 1'b1;
        cycle();
        strayValid = 1'b0;
        runUntilIdle(60);
        irregular = 1'b0;
        cycle();

        // Miss mid-fill is ignored; a miss right after completion chains.
        startMiss(16'h2002);
        for (int i = 0; i < 5; i++) cycle();
        missIn = 1'b1;
        missAddrIn = 16'h4444;
        cycle();
        missIn = 1'b0;
        runUntilIdle(40);
        startMiss(16'h0A0B);
        runUntilIdle(40);
        cycle();

        // Reset after the third returned word, then a clean refill.
        startMiss(16'h3456);
        runUntilRcv(3, 40);
        rstIn = 1'b1;
        cycle();
        rstIn = 1'b0;
        strict = 1'b1;
        cycle();
        strict = 1'b0;
        startMiss(16'h5678);
        runUntilIdle(40);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller for the I-cache and D-cache; one instance per cache.
- On a tag miss it reads one full block from multi-cycle main memory, one word request per cycle.
- Each returned word is written into the cache data array; the tag is written after the last word.
- Drives the fsm_busy level that the hazard/forwarding unit consumes as i_cache_busy / d_cache_busy to stall the pipeline.

Parameters:
- ADDR_W, 16, byte-address width.
- WORD_W, 16, memory word width in bits; words are 2 bytes.
- WORDS, 8, words per cache block; must be a power of 2. Block = 2*WORDS bytes; OFF_W = log2(2*WORDS) = 4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_detected  in  1  cache lookup missed this cycle.
- miss_address  in  ADDR_W  byte address of the missing access.
- memory_data_valid  in  1  memory_data holds the word for the oldest outstanding request.
- memory_data  in  WORD_W  returned read data.
- fsm_busy  out  1  fill in progress; stall request to the hazard unit.
- memory_read_en  out  1  issue a read request this cycle.
- memory_address  out  ADDR_W  byte address of the request.
- write_data_array  out  1  write fill_data into the data array this cycle.
- fill_word  out  log2(WORDS)  word index within the block for the data write.
- fill_data  out  WORD_W  data to write; equals memory_data.
- write_tag_array  out  1  write tag/valid for the block this cycle.
- fill_base  out  ADDR_W  latched block base address, for tag/index.

Behaviour:
- States: IDLE, FILL. Registers: state, base, req_cnt (0..WORDS), rcv_cnt (0..WORDS-1).
- Reset (async): state=IDLE, req_cnt=0, rcv_cnt=0, base=0. All outputs 0 while rst is high and in the first cycle after it.
- fsm_busy is combinational: (state==FILL) | (state==IDLE & miss_detected). The pipeline therefore stalls in the same cycle the miss is seen.
- IDLE, miss_detected=1:
  - base <= miss_address with the low OFF_W bits cleared.
  - req_cnt <= 0, rcv_cnt <= 0; next state FILL.
  - No memory request is issued in this cycle.
- FILL, request side:
  - memory_read_en = (req_cnt < WORDS).
  - memory_address = base + 2*req_cnt, mod 2^ADDR_W; wrap is allowed.
  - req_cnt increments each cycle memory_read_en=1, then saturates at WORDS.
  - Requests issue back-to-back, one per cycle, with no wait on returns.
- FILL, return side, on each memory_data_valid pulse:
  - write_data_array=1, fill_word=rcv_cnt, fill_data=memory_data.
  - Data write is the same cycle as valid; no buffering.
  - rcv_cnt increments.
- Completion: on the valid with rcv_cnt==WORDS-1:
  - write_tag_array=1 in that same cycle.
  - Next state IDLE; fsm_busy falls the following cycle, unless a new miss_detected is present then.
- memory_data_valid with no outstanding request (rcv_cnt==req_cnt, or state==IDLE) is ignored: no writes, no counter change.
- miss_detected during FILL is ignored. miss_address is only sampled in IDLE.
- Back-to-back misses: a miss in the cycle after returning to IDLE starts a new fill immediately, with fsm_busy held high continuously.
- Reset mid-fill: immediate return to IDLE, counters cleared, write strobes drop at once, partial block and tag are not written.
- write_tag_array is asserted exactly once per completed fill. write_data_array is asserted exactly WORDS times per fill.

Test Plan:
- Reset, then idle with memory_data_valid toggling -> all outputs 0, no array writes.
- Miss at 0x1236, memory latency 4 (valid 4 cycles after each request):
  - fill_base=0x1230.
  - Requests 0x1230..0x123E on cycles 1-8 after the miss.
  - Data writes on cycles 5-12 with fill_word 0..7.
  - write_tag_array on cycle 12.
  - fsm_busy high on cycles 0-12, low on cycle 13.
- Miss at 0xFFF8 -> base 0xFFF0, addresses 0xFFF0..0xFFFE; no wrap corruption.
- Irregular returns (gaps of 0-3 cycles between valid pulses), plus a stray valid before the first request -> stray ignored; fill_word strictly sequential 0..7; tag written only with the 8th word.
- miss_detected pulsed with a different address mid-fill -> ignored; base unchanged; a second miss the cycle after completion starts a new fill with fsm_busy never dropping.
- rst asserted after the 3rd returned word -> outputs 0 immediately; no tag write; the next miss restarts at fill_word 0.
